// File: rtl/mips_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the
// MIPS pipeline ID stage.
package mips_pkg;

    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               alu_src;
        logic               reg_dst;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/main_decoder.sv
// Combinational main decoder: opcode to EX/MEM/WB control bundle,
// plus rt-usage, jump and illegal-opcode flags.
module main_decoder
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output logic                o_uses_rt,
    output logic                o_jump,
    output logic                o_illegal
);

    // Opcode table; j and undefined opcodes decode to a bubble
    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_uses_rt = 1'b0;
        o_jump    = 1'b0;
        o_illegal = 1'b0;
        unique case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_uses_rt        = 1'b1;
            end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALUOP_SUB;
                o_uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_J: begin
                o_jump = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_control_unit.sv
// ID-stage control: decode, load-use hazard detection and the
// ID/EX control register with bubble insertion.
module id_control_unit
    import mips_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int REG_AW    = 5,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               id_valid,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               hazard_stall,
    output logic               id_jump,
    output logic               ex_valid,
    output logic [1:0]         ex_alu_op,
    output logic [5:0]         ex_funct,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_reg_write,
    output logic               ex_branch,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_illegal
);

    ctrl_t                r_ctrl;
    logic                 r_valid;
    logic [FUNCT_W-1:0]   r_funct;
    logic [REG_AW-1:0]    r_rs;
    logic [REG_AW-1:0]    r_rt;
    logic [REG_AW-1:0]    r_rd;
    logic                 r_illegal;

    ctrl_t                w_ctrl;
    logic                 w_uses_rt;
    logic                 w_jump;
    logic                 w_illegal;
    logic                 w_load_use;
    logic [OPCODE_W-1:0]  w_opcode;
    logic [REG_AW-1:0]    w_rs;
    logic [REG_AW-1:0]    w_rt;
    logic [REG_AW-1:0]    w_rd;
    logic [FUNCT_W-1:0]   w_funct;
    logic                 w_unused;

    assign w_opcode = id_instr[31:26];
    assign w_rs     = id_instr[21 +: REG_AW];
    assign w_rt     = id_instr[16 +: REG_AW];
    assign w_rd     = id_instr[11 +: REG_AW];
    assign w_funct  = id_instr[5:0];
    assign w_unused = ^id_instr[10:6];

    main_decoder u_dec (
        .i_opcode  (w_opcode),
        .o_ctrl    (w_ctrl),
        .o_uses_rt (w_uses_rt),
        .o_jump    (w_jump),
        .o_illegal (w_illegal)
    );

    // Load in EX whose destination feeds the ID instruction
    always_comb begin
        w_load_use = 1'b0;
        if (HAZARD_EN && r_valid && r_ctrl.mem_read &&
            (r_rt != '0) && id_valid) begin
            w_load_use = (r_rt == w_rs) ||
                         ((r_rt == w_rt) && w_uses_rt);
        end
    end

    // Stall/jump requests; flush squashes both, and a jump held
    // in ID redirects only once it actually proceeds
    always_comb begin
        hazard_stall = id_valid && !flush &&
                       (ex_hold || w_load_use);
        id_jump      = id_valid && w_jump && !flush &&
                       !hazard_stall;
    end

    // ID/EX register: reset > flush > hold > load-use > capture
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!ex_hold && w_load_use)) begin
            r_ctrl    <= CTRL_NOP;
            r_valid   <= 1'b0;
            r_funct   <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (!ex_hold) begin
            if (id_valid && !w_illegal && !w_jump) begin
                r_ctrl    <= w_ctrl;
                r_valid   <= 1'b1;
                r_funct   <= w_funct;
                r_rs      <= w_rs;
                r_rt      <= w_rt;
                r_rd      <= w_rd;
                r_illegal <= 1'b0;
            end else begin
                r_ctrl    <= CTRL_NOP;
                r_valid   <= 1'b0;
                r_funct   <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_illegal <= id_valid && w_illegal;
            end
        end
    end

    assign ex_valid      = r_valid;
    assign ex_alu_op     = r_ctrl.alu_op;
    assign ex_funct      = r_funct;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_reg_dst    = r_ctrl.reg_dst;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_branch     = r_ctrl.branch;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign ex_illegal    = r_illegal;

endmodule
